// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// Multi-cycle ALU execute unit: single-cycle logic/arith ops, shifts iterate one bit per cycle.
// Valid/ready handshake on both request and result sides.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ctrl,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shk_t;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             state_q, state_d;
    shk_t               shk_q, shk_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;
    logic               is_shift;
    shk_t               shk_in;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   work_sh;

    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        shk_in   = SH_LL;
        case (ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1000: begin is_shift = 1'b1; shk_in = SH_LL; alu_res = op_a; end
            4'b1001: begin is_shift = 1'b1; shk_in = SH_RL; alu_res = op_a; end
            4'b1010: begin is_shift = 1'b1; shk_in = SH_RA; alu_res = op_a; end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        work_sh = work_q;
        case (shk_q)
            SH_LL:   work_sh = {work_q[WIDTH-2:0], 1'b0};
            SH_RL:   work_sh = {1'b0, work_q[WIDTH-1:1]};
            SH_RA:   work_sh = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_sh = work_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shk_d     = shk_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // A zero shift amount degenerates to a pass-through with single-cycle latency
                    if (is_shift && (shamt != '0)) begin
                        state_d   = SHIFT;
                        cnt_d     = shamt;
                        work_d    = op_a;
                        shk_d     = shk_in;
                        illegal_d = 1'b0;
                    end else begin
                        state_d   = DONE;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                    end
                end
            end
            SHIFT: begin
                work_d = work_sh;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d   = DONE;
                    result_d  = work_sh;
                    zero_d    = (work_sh == '0);
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shk_q     <= SH_LL;
            cnt_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shk_q     <= shk_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one request, scramble the inputs, count edges until out_valid, then handshake.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ei,
                          input int unsigned ee);
        int unsigned edges;
        ctrl      = c;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        ctrl     = ~c;
        op_a     = ~a;
        op_b     = ~b;
        edges    = 0;
        while (!out_valid && edges < 64) begin
            step();
            edges++;
        end
        check({tag, "_edges"}, edges, ee);
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
        check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check({tag, "_idle_after_hs"}, {30'd0, out_valid, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add",      4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 0);
        run_op("sub_wrap", 4'b0110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 0);
        run_op("sub_eq",   4'b0110, 32'd9,          32'd9,          32'd0,          1'b0, 0);
        run_op("and",      4'b0000, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0, 0);
        run_op("or",       4'b0001, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1'b0, 0);
        run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 0);
        run_op("slt_pos",  4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 0);
        run_op("slt_edge", 4'b0111, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 0);
        run_op("ill_f",    4'b1111, 32'd5,          32'd7,          32'd0,          1'b1, 0);
        run_op("ill_3",    4'b0011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 0);
        run_op("sra4",     4'b1010, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 4);
        run_op("srl4",     4'b1001, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 4);
        run_op("sra1",     4'b1010, 32'h4000_0000,  32'd1,          32'h2000_0000,  1'b0, 1);
        run_op("srl_zero", 4'b1001, 32'd1,          32'd1,          32'd0,          1'b0, 1);
        run_op("sll0",     4'b1000, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b0, 0);
        run_op("sll32",    4'b1000, 32'h1234_5678,  32'd32,         32'h1234_5678,  1'b0, 0);
        run_op("sll31",    4'b1000, 32'd3,          32'd31,         32'h8000_0000,  1'b0, 31);

        // Backpressure: hold result in DONE while a competing request is offered
        ctrl     = 4'b0010;
        op_a     = 32'd100;
        op_b     = 32'd23;
        in_valid = 1'b1;
        step();
        ctrl = 4'b0000;
        op_a = 32'd0;
        op_b = 32'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'd123);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        check("bp_result_kept", result, 32'd123);
        out_ready = 1'b0;
        step();
        check("bp_no_accept", {31'd0, out_valid}, 32'd0);

        // Reset wins over an acceptance on the same edge
        reset    = 1'b1;
        in_valid = 1'b1;
        ctrl     = 4'b0010;
        op_a     = 32'd1;
        op_b     = 32'd1;
        step();
        check("rstpri_valid", {31'd0, out_valid}, 32'd0);
        check("rstpri_result", result, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("rstpri_idle", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset mid-shift aborts the operation
        ctrl     = 4'b1000;
        op_a     = 32'd1;
        op_b     = 32'd31;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("rstmid_no_valid", {31'd0, seen}, 32'd0);
        check("rstmid_idle", {31'd0, in_ready}, 32'd1);

        // Reset in DONE discards the pending result
        ctrl     = 4'b0010;
        op_a     = 32'd2;
        op_b     = 32'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("rstdone_pre_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstdone_valid", {31'd0, out_valid}, 32'd0);
        check("rstdone_result", result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
